// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32I ALU-control decode slice.
// Holds the ALU op-code enumeration, the RV32I opcode/funct constants the
// decoder recognises, and the decoded-bundle struct registered by the decode
// stage.
package alu_pkg;

    // ALU operation codes driven on alu_ctrl.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_XOR = 4'd2,
        ALU_OR  = 4'd3,
        ALU_AND = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_BEQ = 4'd7,
        ALU_BNE = 4'd8
    } alu_op_e;

    // RV32I major opcodes that this decoder understands.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values for register/immediate arithmetic.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct3 values for conditional branches.
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    // funct7 values: base encoding and the SUB/SRA alternate encoding.
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // The ALU shifter only moves by one bit position.
    localparam logic [4:0] SHAMT_ONE  = 5'd1;

    // Width of the saturating illegal-instruction counter.
    localparam int ILLEGAL_CNT_W = 16;

    // Decoded instruction bundle handed to the execute stage.
    typedef struct packed {
        alu_op_e     alu_ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } id_bundle_t;

endpackage

// File: rtl/alu_ctrl_decode_imm_gen.sv
// imm_gen: combinational immediate generator.
// I-type words (OP-IMM) yield sign-extended imm[11:0]; B-type words (BRANCH)
// yield sign-extended {imm[12:1],0}; every other opcode yields zero.
module imm_gen
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    // 13-bit immediate before sign extension; bit 12 is the sign bit.
    logic [12:0] raw_imm;

    // rs1/funct3 bits carry no immediate information in I or B formats.
    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    // Gather the immediate field according to the instruction format.
    always_comb begin
        raw_imm = '0;
        case (instr[6:0])
            OPC_OP_IMM: raw_imm = {instr[31], instr[31:20]};
            OPC_BRANCH: raw_imm = {instr[31], instr[7], instr[30:25],
                                   instr[11:8], 1'b0};
            default:    raw_imm = '0;
        endcase
    end

    // Copy the low bits and replicate the sign bit across the upper ones.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_imm_bit
            if (gi < 13) begin : g_low
                assign imm[gi] = raw_imm[gi];
            end else begin : g_ext
                assign imm[gi] = raw_imm[12];
            end
        end
    endgenerate

endmodule

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: single-entry RV32I decode stage for a minimal ALU.
// Decodes ADD/SUB/XOR/OR/AND, their immediate forms, SLLI/SRLI by one and
// BEQ/BNE into an ALU control bundle, registered behind a valid/ready
// handshake that allows back-to-back hand-offs without bubbles.
// Optional feature: define ALU_DECODE_ILLEGAL_CNT_EN to add a 16-bit
// saturating count of accepted illegal instructions on output illegal_cnt.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_valid,
    output logic [3:0]      alu_ctrl,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            use_imm,
    output logic            reg_write,
    output logic            is_branch,
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    output logic            illegal,
    output logic [15:0]     illegal_cnt
`else
    output logic            illegal
`endif
);

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_field;
    logic [4:0] rs2_field;
    logic [4:0] rd_field;

    assign opcode    = if_instr[6:0];
    assign rd_field  = if_instr[11:7];
    assign funct3    = if_instr[14:12];
    assign rs1_field = if_instr[19:15];
    assign rs2_field = if_instr[24:20];
    assign funct7    = if_instr[31:25];

    // Classification of the incoming word.
    alu_op_e    op_sel;
    logic       op_legal;
    logic       op_imm;
    logic       op_branch;

    // Immediate from the generator and the assembled bundle.
    logic [XLEN-1:0] imm_w;
    id_bundle_t      dec_bundle;

    // Pipeline register state.
    logic       id_valid_reg;
    logic       id_valid_next;
    id_bundle_t bundle_reg;
    id_bundle_t bundle_next;
    logic       capture;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (if_instr),
        .imm   (imm_w)
    );

    // Recognise the supported opcode/funct3/funct7 combinations.
    always_comb begin
        op_sel    = ALU_ADD;
        op_legal  = 1'b0;
        op_imm    = 1'b0;
        op_branch = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    op_legal = 1'b1;
                    case (funct3)
                        F3_ADD_SUB: op_sel = ALU_ADD;
                        F3_XOR:     op_sel = ALU_XOR;
                        F3_OR:      op_sel = ALU_OR;
                        F3_AND:     op_sel = ALU_AND;
                        default:    op_legal = 1'b0;
                    endcase
                end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB)) begin
                    op_legal = 1'b1;
                    op_sel   = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                op_imm   = 1'b1;
                op_legal = 1'b1;
                case (funct3)
                    F3_ADD_SUB: op_sel = ALU_ADD;
                    F3_XOR:     op_sel = ALU_XOR;
                    F3_OR:      op_sel = ALU_OR;
                    F3_AND:     op_sel = ALU_AND;
                    // The shifter moves by exactly one, so any other shamt
                    // (or a non-zero funct7) is rejected.
                    F3_SLL: begin
                        op_sel   = ALU_SLL;
                        op_legal = (funct7 == F7_BASE) && (rs2_field == SHAMT_ONE);
                    end
                    F3_SRL: begin
                        op_sel   = ALU_SRL;
                        op_legal = (funct7 == F7_BASE) && (rs2_field == SHAMT_ONE);
                    end
                    default:    op_legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                op_branch = 1'b1;
                op_legal  = 1'b1;
                case (funct3)
                    F3_BEQ:  op_sel = ALU_BEQ;
                    F3_BNE:  op_sel = ALU_BNE;
                    default: op_legal = 1'b0;
                endcase
            end
            default: op_legal = 1'b0;
        endcase
    end

    // Assemble the bundle; illegal words carry only their register fields.
    always_comb begin
        dec_bundle     = '0;
        dec_bundle.rs1 = rs1_field;
        dec_bundle.rs2 = rs2_field;
        dec_bundle.rd  = rd_field;
        if (op_legal) begin
            dec_bundle.alu_ctrl  = op_sel;
            dec_bundle.imm       = imm_w[31:0];
            dec_bundle.use_imm   = op_imm;
            dec_bundle.is_branch = op_branch;
            dec_bundle.reg_write = !op_branch && (rd_field != 5'd0);
        end else begin
            dec_bundle.illegal   = 1'b1;
        end
    end

    // The stage accepts whenever it is empty or its occupant leaves now.
    assign if_ready = !id_valid_reg || ex_ready;
    assign capture  = if_valid && if_ready && !flush;

    // Next-state: flush empties the stage, otherwise capture or drain.
    always_comb begin
        id_valid_next = id_valid_reg;
        bundle_next   = bundle_reg;
        if (flush) begin
            id_valid_next = 1'b0;
        end else if (capture) begin
            id_valid_next = 1'b1;
            bundle_next   = dec_bundle;
        end else if (ex_ready) begin
            id_valid_next = 1'b0;
        end
    end

    // Pipeline register; reset clears the valid flag and the whole bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_reg <= 1'b0;
            bundle_reg   <= '0;
        end else begin
            id_valid_reg <= id_valid_next;
            bundle_reg   <= bundle_next;
        end
    end

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [ILLEGAL_CNT_W-1:0] illegal_cnt_reg;

    // Count accepted illegal words; capture already excludes flushed ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_reg <= '0;
        end else if (capture && dec_bundle.illegal && (illegal_cnt_reg != {ILLEGAL_CNT_W{1'b1}})) begin
            illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
        end
    end

    assign illegal_cnt = illegal_cnt_reg;
`endif

    assign id_valid  = id_valid_reg;
    assign alu_ctrl  = bundle_reg.alu_ctrl;
    assign rs1       = bundle_reg.rs1;
    assign rs2       = bundle_reg.rs2;
    assign rd        = bundle_reg.rd;
    assign imm       = bundle_reg.imm;
    assign use_imm   = bundle_reg.use_imm;
    assign reg_write = bundle_reg.reg_write;
    assign is_branch = bundle_reg.is_branch;
    assign illegal   = bundle_reg.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb_alu_ctrl_decode: directed plus randomized checks of the decode stage
// against a mask/match instruction table and a valid/ready occupancy model.
// Define ALU_DECODE_ILLEGAL_CNT_EN to also exercise the illegal counter.
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        if_ready;
    logic        id_valid;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        is_branch;
    logic        illegal;
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode #(
        .XLEN (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_ready   (if_ready),
        .flush      (flush),
        .ex_ready   (ex_ready),
        .id_valid   (id_valid),
        .alu_ctrl   (alu_ctrl),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .imm        (imm),
        .use_imm    (use_imm),
        .reg_write  (reg_write),
        .is_branch  (is_branch),
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
`else
        .illegal    (illegal)
`endif
    );

    // Instruction table in mask/match form: ADD SUB XOR OR AND, ADDI XORI
    // ORI ANDI, SLLI SRLI (shamt fixed at 1), BEQ BNE.
    localparam int NT = 13;
    localparam logic [31:0] MASK_T [NT] = '{
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'hFFF0707F, 32'hFFF0707F,
        32'h0000707F, 32'h0000707F};
    localparam logic [31:0] MATCH_T [NT] = '{
        32'h00000033, 32'h40000033, 32'h00004033, 32'h00006033, 32'h00007033,
        32'h00000013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00101013, 32'h00105013,
        32'h00000063, 32'h00001063};
    localparam int OP_T [NT]   = '{0, 1, 2, 3, 4, 0, 2, 3, 4, 5, 6, 7, 8};
    // 0 = register form, 1 = immediate form, 2 = branch
    localparam int KIND_T [NT] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2};

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } exp_t;

    // Expected stage contents.
    logic exp_valid = 1'b0;
    exp_t exp_b = '0;
    int   exp_cnt = 0;
    logic last_cap = 1'b0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   hit;
        int   kind;
        int   off;
        e     = '0;
        hit   = -1;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        for (int k = 0; k < NT; k++) begin
            if ((w & MASK_T[k]) == MATCH_T[k]) hit = k;
        end
        if (hit < 0) begin
            e.illegal = 1'b1;
        end else begin
            kind        = KIND_T[hit];
            e.op        = 4'(OP_T[hit]);
            e.use_imm   = (kind == 1);
            e.is_branch = (kind == 2);
            e.reg_write = (kind != 2) && (w[11:7] != 5'd0);
            off = 0;
            if (kind == 1) begin
                off = int'(w[31:20]);
                if (w[31]) off = off - 4096;
            end else if (kind == 2) begin
                off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
                if (w[31]) off = off - 4096;
            end
            e.imm = off;
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        int          sel;
        int          k;
        logic [31:0] w;
        sel = int'($urandom_range(0, 15));
        w   = $urandom;
        if (sel < 10) begin
            k = int'($urandom_range(0, NT - 1));
            return (w & ~MASK_T[k]) | MATCH_T[k];
        end else if (sel < 13) begin
            // shift-immediate with arbitrary shamt / funct7
            return {w[31:15], (w[12] ? 3'b001 : 3'b101), w[11:7], 7'b0010011};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string t);
        chk({t, ".id_valid"},  32'(id_valid),  32'(exp_valid));
        chk({t, ".alu_ctrl"},  32'(alu_ctrl),  32'(exp_b.op));
        chk({t, ".rs1"},       32'(rs1),       32'(exp_b.rs1));
        chk({t, ".rs2"},       32'(rs2),       32'(exp_b.rs2));
        chk({t, ".rd"},        32'(rd),        32'(exp_b.rd));
        chk({t, ".imm"},       imm,            exp_b.imm);
        chk({t, ".use_imm"},   32'(use_imm),   32'(exp_b.use_imm));
        chk({t, ".reg_write"}, 32'(reg_write), 32'(exp_b.reg_write));
        chk({t, ".is_branch"}, 32'(is_branch), 32'(exp_b.is_branch));
        chk({t, ".illegal"},   32'(illegal),   32'(exp_b.illegal));
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        chk({t, ".illegal_cnt"}, 32'(illegal_cnt), exp_cnt);
`endif
    endtask

    // Called at a negedge with inputs already driven: check if_ready, let
    // one rising edge pass, update the model, compare at the next negedge.
    task automatic run_cycle(input string t);
        logic rdy;
        #1;
        rdy = !exp_valid || ex_ready;
        chk({t, ".if_ready"}, 32'(if_ready), 32'(rdy));
        @(posedge clk);
        last_cap = if_valid && rdy && !flush;
        if (flush) begin
            exp_valid = 1'b0;
        end else if (last_cap) begin
            exp_valid = 1'b1;
            exp_b     = ref_decode(if_instr);
            if (exp_b.illegal && exp_cnt < 65535) exp_cnt++;
        end else if (ex_ready) begin
            exp_valid = 1'b0;
        end
        @(negedge clk);
        chk_all(t);
        $display("txn %s instr=%08h if_valid=%0b flush=%0b ex_ready=%0b cap=%0b id_valid=%0b alu_ctrl=%0d",
                 t, if_instr, if_valid, flush, ex_ready, last_cap, id_valid, alu_ctrl);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_b     = '0;
        exp_cnt   = 0;
    endtask

    initial begin
        // ---- power-on reset
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        chk("por.if_ready", 32'(if_ready), 32'd1);
        chk_all("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---- ADDI x1,x0,5
        if_valid = 1'b1; if_instr = 32'h00500093; ex_ready = 1'b1;
        run_cycle("addi");
        chk("addi.id_valid_c",  32'(id_valid),  32'd1);
        chk("addi.alu_ctrl_c",  32'(alu_ctrl),  32'd0);
        chk("addi.rd_c",        32'(rd),        32'd1);
        chk("addi.imm_c",       imm,            32'd5);
        chk("addi.use_imm_c",   32'(use_imm),   32'd1);
        chk("addi.reg_write_c", 32'(reg_write), 32'd1);

        // ---- BEQ x1,x2,-4 (back-to-back with ADDI)
        if_instr = 32'hFE208EE3;
        run_cycle("beq");
        chk("beq.alu_ctrl_c",  32'(alu_ctrl),  32'd7);
        chk("beq.is_branch_c", 32'(is_branch), 32'd1);
        chk("beq.reg_write_c", 32'(reg_write), 32'd0);
        chk("beq.imm_c",       imm,            32'hFFFFFFFC);

        // ---- stall for three cycles with XOR x3,x1,x2 waiting
        ex_ready = 1'b0; if_instr = 32'h0020C1B3;
        for (int i = 0; i < 3; i++) begin
            run_cycle("stall");
            chk("stall.if_ready_c", 32'(if_ready), 32'd0);
            chk("stall.alu_ctrl_c", 32'(alu_ctrl), 32'd7);
            chk("stall.imm_c",      imm,           32'hFFFFFFFC);
        end
        ex_ready = 1'b1;
        run_cycle("release");
        chk("release.id_valid_c", 32'(id_valid), 32'd1);
        chk("release.alu_ctrl_c", 32'(alu_ctrl), 32'd2);
        chk("release.rd_c",       32'(rd),       32'd3);

        // ---- flush while holding, with an illegal word incoming
        flush = 1'b1; ex_ready = 1'b0; if_instr = 32'h00209093;
        run_cycle("flush");
        chk("flush.id_valid_c", 32'(id_valid), 32'd0);
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        chk("flush.cnt_c", 32'(illegal_cnt), 32'd0);
`endif
        flush = 1'b0;

        // ---- SLLI with shamt=2 is illegal
        ex_ready = 1'b1;
        run_cycle("slli2");
        chk("slli2.illegal_c",   32'(illegal),   32'd1);
        chk("slli2.alu_ctrl_c",  32'(alu_ctrl),  32'd0);
        chk("slli2.reg_write_c", 32'(reg_write), 32'd0);
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        chk("slli2.cnt_c", 32'(illegal_cnt), 32'd1);
`endif

        // ---- randomized traffic
        for (int n = 0; n < 600; n++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            if_instr = gen_instr();
            run_cycle("rand");
        end

        // ---- reset asserted mid-stream with a word in flight
        flush = 1'b0; if_valid = 1'b1; ex_ready = 1'b1; if_instr = 32'h00500093;
        run_cycle("prerst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst.if_ready", 32'(if_ready), 32'd1);
        chk("midrst.id_valid", 32'(id_valid), 32'd0);
        chk("midrst.alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("midrst.rd",       32'(rd),       32'd0);
        chk("midrst.imm",      imm,           32'd0);
        chk_all("midrst");
        @(negedge clk);
        chk_all("inrst");
        rst_n = 1'b1; if_valid = 1'b0;
        run_cycle("postrst");

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        // ---- saturation: 0x10000 accepted illegal words back to back
        if_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0; if_instr = 32'h00209093;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("sat.cnt_fffe", 32'(illegal_cnt), 32'h0000FFFE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat.cnt_ffff", 32'(illegal_cnt), 32'h0000FFFF);
        exp_valid = 1'b1;
        exp_b     = ref_decode(if_instr);
        exp_cnt   = 65535;
        chk_all("sat");
        $display("txn sat instr=%08h captures=65536 illegal_cnt=%0h", if_instr, illegal_cnt);
        if_valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode.md
ALU_CTRL_DECODE -- requirements
Module: alu_ctrl_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_valid  in  1  instruction from fetch is valid.
REQ-005 SHALL have port if_instr  in  32  RV32I instruction word.
REQ-006 SHALL have port if_ready  out  1  decode stage can accept this cycle.
REQ-007 SHALL have port flush  in  1  discard held and incoming instruction.
REQ-008 SHALL have port ex_ready  in  1  execute stage accepts the held instruction.
REQ-009 SHALL have port id_valid  out  1  decoded bundle is valid.
REQ-010 SHALL have port alu_ctrl  out  4  ALU op code, taken from the shared package.
REQ-011 SHALL have ports rs1, rs2, rd  out  5 each  register indices.
REQ-012 SHALL have port imm  out  32  sign-extended immediate.
REQ-013 SHALL have ports use_imm, reg_write, is_branch, illegal  out  1 each  decode flags.

Function
REQ-014 SHALL map ADD/ADDI->0, SUB->1, XOR/XORI->2, OR/ORI->3, AND/ANDI->4, SLLI->5, SRLI->6, BEQ->7, BNE->8.
REQ-015 SHALL treat SLLI/SRLI as legal only with shamt==1 (the ALU shifts by exactly one).
REQ-016 SHALL flag any other opcode/funct3/funct7 combination as illegal=1, alu_ctrl=0, reg_write=0, is_branch=0.
REQ-017 SHALL set use_imm=1 for I-type ops, is_branch=1 and reg_write=0 for BEQ/BNE, and reg_write=0 when rd==0.
REQ-018 SHALL form imm as I-type imm[11:0] or B-type {imm[12:1],0}, sign-extended; R-type imm=0.
REQ-019 SHALL drive if_ready = !id_valid || ex_ready, combinationally.
REQ-020 SHALL register the decoded bundle and set id_valid=1 one cycle after if_valid && if_ready && !flush.
REQ-021 SHALL clear id_valid when ex_ready=1 and no new capture occurs that cycle.
REQ-022 SHALL hold all outputs stable while id_valid=1 and ex_ready=0.
REQ-023 SHALL on flush=1 clear id_valid next cycle and drop the same-cycle incoming instruction; flush wins over capture and stall.
REQ-024 SHALL support back-to-back captures: held bundle handed off and new one captured in the same cycle, no bubble.

Reset
REQ-025 SHALL on rst_n=0 immediately clear id_valid, alu_ctrl, rs1, rs2, rd, imm, use_imm, reg_write, is_branch, illegal to 0.
REQ-026 SHALL drive if_ready=1 during and after reset; an instruction in flight at reset assertion is lost.

Configuration
REQ-027 SHALL, with ALU_DECODE_ILLEGAL_CNT_EN defined, add output illegal_cnt (16 bits) counting accepted illegal instructions, saturating at 0xFFFF, reset to 0, not incremented on flushed captures.
REQ-028 SHALL, without ALU_DECODE_ILLEGAL_CNT_EN, omit the illegal_cnt port and counter; all other behaviour identical.

Structure
REQ-029 SHALL take the ALU op-code constants (0-8), RV32I opcode/funct3 constants and the decoded-bundle struct typedef from shared package alu_pkg.
REQ-030 SHALL place immediate generation in combinational sub-module imm_gen (instr in, imm out).

Verification
REQ-031 SHALL check reset: assert rst_n=0 mid-stream -> id_valid=0, all outputs 0, if_ready=1 same cycle.
REQ-032 SHALL check decode: if_instr=0x00500093 (ADDI x1,x0,5), ex_ready=1 -> next cycle id_valid=1, alu_ctrl=0, rd=1, imm=5, use_imm=1, reg_write=1.
REQ-033 SHALL check branch: 0xFE208EE3 (BEQ x1,x2,-4) -> alu_ctrl=7, is_branch=1, reg_write=0, imm=0xFFFFFFFC.
REQ-034 SHALL check stall: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, bundle unchanged; ex_ready=1 -> next instruction captured with no bubble.
REQ-035 SHALL check flush: flush=1 with if_valid=1 and id_valid=1 -> id_valid=0 next cycle, incoming dropped, illegal_cnt unchanged.
REQ-036 SHALL check illegal: SLLI shamt=2 (0x00209093) -> illegal=1, alu_ctrl=0; with ALU_DECODE_ILLEGAL_CNT_EN, 0x10000 such instructions -> illegal_cnt=0xFFFF.
